sort_pipe: RTL and testbench

SORT_PIPE -- requirements
Module: sort_pipe

---
 rtl/sort_pkg.sv | 14 +
 rtl/cmp_swap.sv | 40 ++++
 rtl/sort_pipe.sv | 123 ++++++++++++
 tb/tb_sort_pipe.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared defaults and mode encoding for the odd-even transposition sorter.
package sort_pkg;

    localparam int DW_DEF = 8;
    localparam int N_DEF  = 4;
    localparam int TW_DEF = 4;

    // Per-vector sort direction carried alongside the data.
    typedef enum logic {
        MODE_ASC  = 1'b0,
        MODE_DESC = 1'b1
    } sort_mode_e;

endpackage

// File: rtl/cmp_swap.sv
// Single compare-exchange cell: lo_out keeps the lower index position,
// hi_out the higher one. Equal elements are never swapped, so the sort
// is stable with respect to the element positions.
module cmp_swap
    import sort_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int SIGNED = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          desc,
    output logic [DW-1:0] lo_out,
    output logic [DW-1:0] hi_out
);

    logic w_a_gt_b;
    logic w_a_lt_b;
    logic w_swap;

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [DW-1:0] w_sa;
            logic signed [DW-1:0] w_sb;
            assign w_sa     = a;
            assign w_sb     = b;
            assign w_a_gt_b = (w_sa > w_sb);
            assign w_a_lt_b = (w_sa < w_sb);
        end else begin : g_unsigned
            assign w_a_gt_b = (a > b);
            assign w_a_lt_b = (a < b);
        end
    endgenerate

    // Swap only when the pair is strictly out of order for the requested direction.
    assign w_swap = (desc == MODE_DESC) ? w_a_lt_b : w_a_gt_b;
    assign lo_out = w_swap ? b : a;
    assign hi_out = w_swap ? a : b;

endmodule

// File: rtl/sort_pipe.sv
// Pipelined odd-even transposition sorter with valid/ready handshake on
// both sides. N registered stages; stage k compare-exchanges the pairs
// whose lower index has the same parity as k. Each stage holds its own
// valid bit so bubbles collapse while the output is stalled.
module sort_pipe
    import sort_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int N      = N_DEF,
    parameter int TW     = TW_DEF,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic [TW-1:0]   in_tag,
    input  logic            in_desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    output logic [TW-1:0]   out_tag,
    output logic            out_desc
);

    logic [N-1:0]    r_vld_p;
    logic [N*DW-1:0] r_data_p [N];
    logic [TW-1:0]   r_tag_p  [N];
    logic [N-1:0]    r_desc_p;

    logic [N:0]      w_en;
    logic [N-1:0]    w_src_vld;
    logic [N-1:0]    w_src_desc;
    logic [TW-1:0]   w_src_tag [N];
    logic [N*DW-1:0] w_net_p   [N];

    assign w_src_vld  = {r_vld_p[N-2:0], in_valid};
    assign w_src_desc = {r_desc_p[N-2:0], in_desc};

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            logic [N*DW-1:0] w_src;
            logic [N*DW-1:0] w_net;

            if (k == 0) begin : g_first
                assign w_src        = in_data;
                assign w_src_tag[k] = in_tag;
            end else begin : g_next
                assign w_src        = r_data_p[k-1];
                assign w_src_tag[k] = r_tag_p[k-1];
            end

            for (genvar j = 0; j < N - 1; j++) begin : g_pair
                if ((j % 2) == (k % 2)) begin : g_cs
                    cmp_swap #(
                        .DW     (DW),
                        .SIGNED (SIGNED)
                    ) u_cmp_swap (
                        .a      (w_src[j*DW +: DW]),
                        .b      (w_src[(j+1)*DW +: DW]),
                        .desc   (w_src_desc[k]),
                        .lo_out (w_net[j*DW +: DW]),
                        .hi_out (w_net[(j+1)*DW +: DW])
                    );
                end
            end

            // Elements not covered by any pair in this stage pass straight through.
            for (genvar i = 0; i < N; i++) begin : g_pass
                if (!(((i % 2) == (k % 2)) && (i + 1 < N)) &&
                    !((i >= 1) && ((i % 2) != (k % 2)))) begin : g_thru
                    assign w_net[i*DW +: DW] = w_src[i*DW +: DW];
                end
            end

            assign w_net_p[k] = w_net;
        end
    endgenerate

    // Load enables ripple back from the output: a stage loads when empty or when its successor takes its contents.
    always_comb begin
        w_en    = '0;
        w_en[N] = out_ready;
        for (int k = N - 1; k >= 0; k--) begin
            w_en[k] = !r_vld_p[k] || w_en[k+1];
        end
    end

    // Stage valid bits: the only state that reset clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_en[k]) begin
                    r_vld_p[k] <= w_src_vld[k];
                end
            end
        end
    end

    // Stage payload: data, tag and mode advance together with their valid bit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (w_en[k]) begin
                r_data_p[k] <= w_net_p[k];
                r_tag_p[k]  <= w_src_tag[k];
                r_desc_p[k] <= w_src_desc[k];
            end
        end
    end

    // in_ready is held low during reset; otherwise it is the stage-0 load enable.
    assign in_ready  = rst_n && w_en[0];

    // Payload is masked when no result is present so idle outputs read as zero.
    assign out_valid = r_vld_p[N-1];
    assign out_data  = out_valid ? r_data_p[N-1] : '0;
    assign out_tag   = out_valid ? r_tag_p[N-1]  : '0;
    assign out_desc  = out_valid ? r_desc_p[N-1] : 1'b0;

endmodule

// File: tb/tb_sort_pipe.sv
// Directed bench for sort_pipe: an unsigned and a signed instance share
// the same stimulus; each test task checks its own expected values.
module tb_sort_pipe;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int TW = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [N*DW-1:0] in_data;
    logic [TW-1:0]   in_tag;
    logic            in_desc;
    logic            out_ready;

    logic            in_ready0, in_ready1;
    logic            out_valid0, out_valid1;
    logic [N*DW-1:0] out_data0, out_data1;
    logic [TW-1:0]   out_tag0, out_tag1;
    logic            out_desc0, out_desc1;

    int checks;
    int errors;

    sort_pipe #(.DW(DW), .N(N), .TW(TW), .SIGNED(0)) u_dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_desc   (in_desc),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_data  (out_data0),
        .out_tag   (out_tag0),
        .out_desc  (out_desc0)
    );

    sort_pipe #(.DW(DW), .N(N), .TW(TW), .SIGNED(1)) u_dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_desc   (in_desc),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .out_tag   (out_tag1),
        .out_desc  (out_desc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Element 0 is the first argument (lowest bits).
    function automatic logic [31:0] v4(input logic [7:0] e0, input logic [7:0] e1,
                                       input logic [7:0] e2, input logic [7:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = v4(8'd1, 8'd2, 8'd3, 8'd4);
        in_tag    = 4'd7;
        in_desc   = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b/%0b exp 0", out_valid0, out_valid1);
        end
        checks++;
        if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %0b/%0b exp 0", in_ready0, in_ready1);
        end
        checks++;
        if (out_data0 !== 32'h0 || out_tag0 !== 4'h0 || out_desc0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_payload got %h/%h/%0b exp 0", out_data0, out_tag0, out_desc0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got %0b exp 1", in_ready0);
        end
    endtask

    task automatic test_ascending();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v4(8'd3, 8'd1, 8'd4, 8'd2);
        in_tag    = 4'd5;
        in_desc   = 1'b0;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL asc_in_ready got %0b exp 1", in_ready0);
        end
        cyc();
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            checks++;
            if (out_valid0 !== 1'b0) begin
                errors++;
                $display("FAIL asc_early_valid cycle %0d got %0b exp 0", c, out_valid0);
            end
            cyc();
        end
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== v4(8'd1, 8'd2, 8'd3, 8'd4) ||
            out_tag0 !== 4'd5 || out_desc0 !== 1'b0) begin
            errors++;
            $display("FAIL asc_result got v%0b %h t%0d d%0b exp v1 %h t5 d0",
                     out_valid0, out_data0, out_tag0, out_desc0, v4(8'd1, 8'd2, 8'd3, 8'd4));
        end
        cyc();
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL asc_drained got %0b exp 0", out_valid0);
        end
        cyc();
    endtask

    task automatic test_signed();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v4(8'hFF, 8'h05, 8'h80, 8'h00);
        in_tag    = 4'd1;
        in_desc   = 1'b1;
        cyc();
        in_tag    = 4'd2;
        in_desc   = 1'b0;
        cyc();
        in_valid  = 1'b0;
        cyc();
        cyc();
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== v4(8'h05, 8'h00, 8'hFF, 8'h80) ||
            out_tag1 !== 4'd1 || out_desc1 !== 1'b1) begin
            errors++;
            $display("FAIL signed_desc got v%0b %h t%0d d%0b exp v1 %h t1 d1",
                     out_valid1, out_data1, out_tag1, out_desc1, v4(8'h05, 8'h00, 8'hFF, 8'h80));
        end
        checks++;
        if (out_data0 !== v4(8'hFF, 8'h80, 8'h05, 8'h00)) begin
            errors++;
            $display("FAIL unsigned_desc got %h exp %h", out_data0, v4(8'hFF, 8'h80, 8'h05, 8'h00));
        end
        cyc();
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== v4(8'h00, 8'h05, 8'h80, 8'hFF) ||
            out_tag0 !== 4'd2 || out_desc0 !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_asc got v%0b %h t%0d d%0b exp v1 %h t2 d0",
                     out_valid0, out_data0, out_tag0, out_desc0, v4(8'h00, 8'h05, 8'h80, 8'hFF));
        end
        checks++;
        if (out_data1 !== v4(8'h80, 8'hFF, 8'h00, 8'h05)) begin
            errors++;
            $display("FAIL signed_asc got %h exp %h", out_data1, v4(8'h80, 8'hFF, 8'h00, 8'h05));
        end
        cyc();
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] bb_in  [6];
        logic [31:0] bb_exp [6];
        logic        bb_desc [6];
        int          tx;
        int          rx;
        logic        stalled;
        logic [31:0] held_d;
        logic [3:0]  held_t;
        logic        held_desc;

        bb_in[0] = v4(8'd5,  8'd3,   8'd9,   8'd1);   bb_desc[0] = 1'b0;
        bb_in[1] = v4(8'd2,  8'd8,   8'd2,   8'd6);   bb_desc[1] = 1'b1;
        bb_in[2] = v4(8'd0,  8'd255, 8'd128, 8'd127); bb_desc[2] = 1'b0;
        bb_in[3] = v4(8'd4,  8'd4,   8'd1,   8'd4);   bb_desc[3] = 1'b1;
        bb_in[4] = v4(8'd10, 8'd20,  8'd30,  8'd40);  bb_desc[4] = 1'b1;
        bb_in[5] = v4(8'd40, 8'd30,  8'd20,  8'd10);  bb_desc[5] = 1'b0;
        bb_exp[0] = v4(8'd1,  8'd3,   8'd5,   8'd9);
        bb_exp[1] = v4(8'd8,  8'd6,   8'd2,   8'd2);
        bb_exp[2] = v4(8'd0,  8'd127, 8'd128, 8'd255);
        bb_exp[3] = v4(8'd4,  8'd4,   8'd4,   8'd1);
        bb_exp[4] = v4(8'd40, 8'd30,  8'd20,  8'd10);
        bb_exp[5] = v4(8'd10, 8'd20,  8'd30,  8'd40);

        tx        = 0;
        rx        = 0;
        stalled   = 1'b0;
        held_d    = '0;
        held_t    = '0;
        held_desc = 1'b0;
        for (int cnt = 0; cnt < 60 && rx < 6; cnt++) begin
            out_ready = (cnt % 2 == 0);
            if (tx < 6) begin
                in_valid = 1'b1;
                in_data  = bb_in[tx];
                in_tag   = tx[3:0];
                in_desc  = bb_desc[tx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                checks++;
                if (out_valid0 !== 1'b1 || out_data0 !== held_d ||
                    out_tag0 !== held_t || out_desc0 !== held_desc) begin
                    errors++;
                    $display("FAIL b2b_stable got %h t%0d exp %h t%0d", out_data0, out_tag0, held_d, held_t);
                end
            end
            if (out_valid0 && out_ready) begin
                checks++;
                if (out_data0 !== bb_exp[rx] || out_tag0 !== rx[3:0] || out_desc0 !== bb_desc[rx]) begin
                    errors++;
                    $display("FAIL b2b_out%0d got %h t%0d d%0b exp %h t%0d d%0b",
                             rx, out_data0, out_tag0, out_desc0, bb_exp[rx], rx, bb_desc[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready0) tx++;
            stalled   = out_valid0 && !out_ready;
            held_d    = out_data0;
            held_t    = out_tag0;
            held_desc = out_desc0;
            cyc();
        end
        in_valid = 1'b0;
        checks++;
        if (rx !== 6) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 6", rx);
        end
        out_ready = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_stall_fill();
        logic [31:0] sf_in  [5];
        logic [31:0] sf_exp [5];
        logic        sf_desc [5];
        logic [31:0] held_d;

        sf_in[0] = v4(8'd7, 8'd7, 8'd7, 8'd0); sf_desc[0] = 1'b0;
        sf_in[1] = v4(8'd1, 8'd2, 8'd3, 8'd4); sf_desc[1] = 1'b1;
        sf_in[2] = v4(8'd9, 8'd9, 8'd0, 8'd9); sf_desc[2] = 1'b0;
        sf_in[3] = v4(8'd3, 8'd3, 8'd3, 8'd3); sf_desc[3] = 1'b1;
        sf_in[4] = v4(8'd6, 8'd5, 8'd4, 8'd3); sf_desc[4] = 1'b0;
        sf_exp[0] = v4(8'd0, 8'd7, 8'd7, 8'd7);
        sf_exp[1] = v4(8'd4, 8'd3, 8'd2, 8'd1);
        sf_exp[2] = v4(8'd0, 8'd9, 8'd9, 8'd9);
        sf_exp[3] = v4(8'd3, 8'd3, 8'd3, 8'd3);
        sf_exp[4] = v4(8'd3, 8'd4, 8'd5, 8'd6);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = sf_in[i];
            in_tag   = 4'(9 + i);
            in_desc  = sf_desc[i];
            #1;
            checks++;
            if (in_ready0 !== 1'b1) begin
                errors++;
                $display("FAIL fill_in_ready%0d got %0b exp 1", i, in_ready0);
            end
            cyc();
        end
        in_data = sf_in[4];
        in_tag  = 4'd13;
        in_desc = sf_desc[4];
        #1;
        checks++;
        if (in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL fill_full_in_ready got %0b exp 0", in_ready0);
        end
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== sf_exp[0] || out_tag0 !== 4'd9) begin
            errors++;
            $display("FAIL fill_head got v%0b %h t%0d exp v1 %h t9", out_valid0, out_data0, out_tag0, sf_exp[0]);
        end
        held_d = out_data0;
        cyc();
        checks++;
        if (in_ready0 !== 1'b0 || out_data0 !== held_d) begin
            errors++;
            $display("FAIL fill_hold got rdy%0b %h exp rdy0 %h", in_ready0, out_data0, held_d);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL fill_release_in_ready got %0b exp 1", in_ready0);
        end
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (out_valid0 !== 1'b1 || out_data0 !== sf_exp[r] ||
                out_tag0 !== 4'(9 + r) || out_desc0 !== sf_desc[r]) begin
                errors++;
                $display("FAIL fill_out%0d got v%0b %h t%0d d%0b exp v1 %h t%0d d%0b",
                         r, out_valid0, out_data0, out_tag0, out_desc0, sf_exp[r], 9 + r, sf_desc[r]);
            end
            cyc();
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL fill_drained got %0b exp 0", out_valid0);
        end
        cyc();
    endtask

    task automatic test_midflight_reset();
        int w;

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v4(8'd9, 8'd8, 8'd7, 8'd6);
        in_tag    = 4'd1;
        in_desc   = 1'b0;
        cyc();
        in_tag    = 4'd2;
        in_desc   = 1'b1;
        cyc();
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        cyc();
        rst_n     = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_valid0 !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale cycle %0d got v%0b t%0d exp v0", c, out_valid0, out_tag0);
            end
            cyc();
        end
        in_valid = 1'b1;
        in_data  = v4(8'd2, 8'd1, 8'd0, 8'd3);
        in_tag   = 4'd3;
        in_desc  = 1'b0;
        cyc();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid0 && w < 10) begin
            cyc();
            w++;
        end
        checks++;
        if (out_valid0 !== 1'b1 || w !== 3) begin
            errors++;
            $display("FAIL midreset_latency got v%0b after %0d exp v1 after 3", out_valid0, w);
        end
        checks++;
        if (out_tag0 !== 4'd3 || out_data0 !== v4(8'd0, 8'd1, 8'd2, 8'd3)) begin
            errors++;
            $display("FAIL midreset_first got %h t%0d exp %h t3", out_data0, out_tag0, v4(8'd0, 8'd1, 8'd2, 8'd3));
        end
        cyc();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        in_desc   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_ascending();
        test_signed();
        test_back_to_back();
        test_stall_fill();
        test_midflight_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
